// File: rtl/text_arb_pkg.sv
// Shared types and widths for the text-draw arbiter.
package text_arb_pkg;

  localparam int unsigned COORD_W = 11;
  localparam int unsigned CHAR_W  = 7;
  localparam int unsigned WD_W    = 20;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    RELEASE = 2'd2
  } state_e;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin pick: first set request after rr_ptr, wrapping.
module rr_picker #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic               valid_c,
  output logic [IDX_W-1:0]   winner_c
);

  // Scan offsets 1..NUM_REQ from the pointer; the first hit wins.
  always_comb begin
    int unsigned idx;
    idx      = 0;
    valid_c  = 1'b0;
    winner_c = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = (32'(rr_ptr) + k) % NUM_REQ;
      if (!valid_c && req[IDX_W'(idx)]) begin
        valid_c  = 1'b1;
        winner_c = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/text_draw_arbiter.sv
// Shares one string-drawing engine between NUM_REQ text clients, with a watchdog.
module text_draw_arbiter
  import text_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned STR_LEN     = 6,
  parameter int unsigned COLOR_W     = 24,
  parameter int unsigned GAP_CYC     = 3,
  parameter int unsigned TIMEOUT_CYC = 200000
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_REQ-1:0]                  req,
  input  logic [NUM_REQ*STR_LEN*CHAR_W-1:0]   req_str,
  input  logic [NUM_REQ*COORD_W-1:0]          req_x,
  input  logic [NUM_REQ*COORD_W-1:0]          req_y,
  input  logic [NUM_REQ*COLOR_W-1:0]          req_color,
  output logic [NUM_REQ-1:0]                  ack,
  output logic                                timeout_err,
  output logic                                busy,
  output logic [$clog2(NUM_REQ)-1:0]          owner,
  output logic                                eng_start,
  output logic [STR_LEN*CHAR_W-1:0]           eng_str,
  output logic [COORD_W-1:0]                  eng_x0,
  output logic [COORD_W-1:0]                  eng_y0,
  input  logic                                eng_done,
  input  logic [COORD_W-1:0]                  eng_x,
  input  logic [COORD_W-1:0]                  eng_y,
  output logic [COORD_W-1:0]                  pix_x,
  output logic [COORD_W-1:0]                  pix_y,
  output logic [COLOR_W-1:0]                  pix_color,
  output logic                                pix_we
);

  localparam int unsigned OWN_W = $clog2(NUM_REQ);
  localparam int unsigned STR_W = STR_LEN * CHAR_W;
  localparam int unsigned GAP_W = $clog2(GAP_CYC + 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYC - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

  // Per-client views of the flattened operand buses.
  logic [STR_W-1:0]   str_arr   [NUM_REQ];
  logic [COORD_W-1:0] x_arr     [NUM_REQ];
  logic [COORD_W-1:0] y_arr     [NUM_REQ];
  logic [COLOR_W-1:0] color_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign str_arr[i]   = req_str[i*STR_W +: STR_W];
    assign x_arr[i]     = req_x[i*COORD_W +: COORD_W];
    assign y_arr[i]     = req_y[i*COORD_W +: COORD_W];
    assign color_arr[i] = req_color[i*COLOR_W +: COLOR_W];
  end

  state_e             state_q, state_d;
  logic [OWN_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [OWN_W-1:0]   owner_q, owner_d;
  logic [WD_W-1:0]    wd_q, wd_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [STR_W-1:0]   eng_str_q, eng_str_d;
  logic [COORD_W-1:0] eng_x0_q, eng_x0_d, eng_y0_q, eng_y0_d;
  logic [COLOR_W-1:0] pix_color_q, pix_color_d;
  logic               eng_start_q, eng_start_d;
  logic               busy_q, busy_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic               timeout_err_q, timeout_err_d;
  logic [COORD_W-1:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic               pix_we_q, pix_we_d;

  logic               grant_valid_c;
  logic [OWN_W-1:0]   grant_idx_c;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (OWN_W)
  ) u_picker (
    .req      (req),
    .rr_ptr   (rr_ptr_q),
    .valid_c  (grant_valid_c),
    .winner_c (grant_idx_c)
  );

  // Next-state and register updates for grant, run/watchdog and release gap.
  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    owner_d       = owner_q;
    wd_d          = wd_q;
    gap_d         = gap_q;
    eng_str_d     = eng_str_q;
    eng_x0_d      = eng_x0_q;
    eng_y0_d      = eng_y0_q;
    pix_color_d   = pix_color_q;
    eng_start_d   = eng_start_q;
    busy_d        = busy_q;
    ack_d         = '0;
    timeout_err_d = 1'b0;
    pix_we_d      = (state_q == RUN);
    pix_x_d       = eng_x;
    pix_y_d       = eng_y;

    case (state_q)
      IDLE: begin
        if (grant_valid_c) begin
          eng_str_d   = str_arr[grant_idx_c];
          eng_x0_d    = x_arr[grant_idx_c];
          eng_y0_d    = y_arr[grant_idx_c];
          pix_color_d = color_arr[grant_idx_c];
          owner_d     = grant_idx_c;
          rr_ptr_d    = grant_idx_c;
          eng_start_d = 1'b1;
          busy_d      = 1'b1;
          wd_d        = '0;
          state_d     = RUN;
        end
      end
      RUN: begin
        // Done wins over a watchdog expiry in the same cycle.
        if (eng_done) begin
          ack_d[owner_q] = 1'b1;
          eng_start_d    = 1'b0;
          gap_d          = '0;
          state_d        = RELEASE;
        end else if (wd_q == WD_LAST) begin
          ack_d[owner_q] = 1'b1;
          timeout_err_d  = 1'b1;
          eng_start_d    = 1'b0;
          gap_d          = '0;
          state_d        = RELEASE;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      RELEASE: begin
        // Hold start low long enough for the engine to re-arm.
        if (gap_q == GAP_LAST) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: begin
        eng_start_d = 1'b0;
        busy_d      = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // State and output registers; reset drops the engine start at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      rr_ptr_q      <= OWN_W'(NUM_REQ - 1);
      owner_q       <= '0;
      wd_q          <= '0;
      gap_q         <= '0;
      eng_str_q     <= '0;
      eng_x0_q      <= '0;
      eng_y0_q      <= '0;
      pix_color_q   <= '0;
      eng_start_q   <= 1'b0;
      busy_q        <= 1'b0;
      ack_q         <= '0;
      timeout_err_q <= 1'b0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      pix_we_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      owner_q       <= owner_d;
      wd_q          <= wd_d;
      gap_q         <= gap_d;
      eng_str_q     <= eng_str_d;
      eng_x0_q      <= eng_x0_d;
      eng_y0_q      <= eng_y0_d;
      pix_color_q   <= pix_color_d;
      eng_start_q   <= eng_start_d;
      busy_q        <= busy_d;
      ack_q         <= ack_d;
      timeout_err_q <= timeout_err_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      pix_we_q      <= pix_we_d;
    end
  end

  assign ack         = ack_q;
  assign timeout_err = timeout_err_q;
  assign busy        = busy_q;
  assign owner       = owner_q;
  assign eng_start   = eng_start_q;
  assign eng_str     = eng_str_q;
  assign eng_x0      = eng_x0_q;
  assign eng_y0      = eng_y0_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign pix_color   = pix_color_q;
  assign pix_we      = pix_we_q;

endmodule

// File: doc/text_draw_arbiter.md
# text_draw_arbiter

Round-robin arbiter and sequencer that shares one string-drawing engine (string-to-pixel stream) between NUM_REQ text clients (score, labels, messages). It latches the winning client's string, origin and colour, runs the engine's level-start/done handshake, and tags the engine's pixel stream with the owner's colour and a write enable for the framebuffer writer. A watchdog aborts a hung draw.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (≥2)
- STR_LEN, 6, characters per string, 7-bit ASCII, index STR_LEN-1 drawn first
- COLOR_W, 24, pixel colour width
- GAP_CYC, 3, idle cycles with engine start low between jobs (≥2)
- TIMEOUT_CYC, 200000, watchdog limit in cycles while running (< 2^20)

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- req  in  NUM_REQ  level request per client
- req_str  in  NUM_REQ×STR_LEN×7  string per client
- req_x, req_y  in  NUM_REQ×11 each  string origin per client
- req_color  in  NUM_REQ×COLOR_W  colour per client
- ack  out  NUM_REQ  one-cycle completion pulse to owner
- timeout_err  out  1  one-cycle pulse with ack when job aborted by watchdog
- busy  out  1  high from grant until return to IDLE
- owner  out  $clog2(NUM_REQ)  index of current/last granted client
- eng_start  out  1  engine start, held high for whole job
- eng_str  out  STR_LEN×7  latched string to engine
- eng_x0, eng_y0  out  11 each  latched origin to engine
- eng_done  in  1  engine completion
- eng_x, eng_y  in  11 each  engine pixel coordinates
- pix_x, pix_y  out  11 each  registered pixel coordinates
- pix_color  out  COLOR_W  latched colour of owner
- pix_we  out  1  framebuffer write enable

## Operation
- States: IDLE, RUN, RELEASE.
- IDLE: req sampled every cycle. Any bit set → winner = first set bit searching cyclically from rr_ptr+1; on that edge latch str/x/y/color into eng_str/eng_x0/eng_y0/pix_color, owner←winner, rr_ptr←winner, eng_start←1, busy←1, watchdog←0, go RUN.
- RUN: eng_start high; watchdog increments. eng_done=1 → ack[owner] pulse, eng_start←0, go RELEASE. Watchdog == TIMEOUT_CYC-1 without done → ack[owner] and timeout_err pulse, eng_start←0, go RELEASE. eng_done and timeout same cycle: normal completion, no timeout_err.
- RELEASE: eng_start low for GAP_CYC cycles (gap counter), then IDLE with busy←0. Engine must see start low to re-arm.
- req changes during RUN/RELEASE ignored; dropping req mid-job does not cancel, ack still pulses. Client must drop req within GAP_CYC cycles of ack or is served again (subject to rotation).
- pix_we = 1 one cycle after each RUN cycle (registered), 0 otherwise; pix_x/pix_y = eng_x/eng_y delayed one cycle. Last pixel of job (cycle eng_done seen) is written.
- Operand registers and owner hold their values outside RUN.

## Timing
- Reset (async assert, sync deassert by upstream): IDLE, eng_start=0, busy=0, ack=0, timeout_err=0, pix_we=0, pix_x=pix_y=0, pix_color=0, eng_str=0, eng_x0=eng_y0=0, owner=0, rr_ptr=NUM_REQ-1 (req[0] has first priority). Reset mid-job drops eng_start immediately; no ack.
- Grant latency: req seen in IDLE at edge N → eng_start=1 after edge N.
- eng_done at edge M → ack, eng_start=0 after edge M; IDLE after edge M+GAP_CYC; earliest next eng_start after edge M+GAP_CYC+1.
- pix outputs: 1-cycle latency from eng_x/eng_y.
- Watchdog: 20-bit, cleared on grant.

## Structure
- Package text_arb_pkg: state enum (IDLE, RUN, RELEASE), COORD_W=11, CHAR_W=7.
- Sub-module rr_picker: combinational round-robin selection (req vector, rr_ptr → valid, winner index). Rest (FSM, counters, operand/pixel registers) in text_draw_arbiter.

## Test plan
- Single client: req=0001, engine model raises done after 100 cycles → eng_start high 100 cycles, ack[0] one pulse, busy low GAP_CYC cycles later, eng_x0/eng_y0/eng_str match client 0.
- Rotation: req=1111 held → grants order 0,1,2,3,0; each owner's pix_color appears with pix_we.
- Fairness after skip: rr_ptr=1, req=1001 → client 3 granted before client 0.
- Watchdog: TIMEOUT_CYC=50, done never asserted → ack[owner] and timeout_err at cycle 50, eng_start low ≥GAP_CYC cycles.
- Done on timeout cycle: done at watchdog=TIMEOUT_CYC-1 → ack only, timeout_err=0.
- Async reset mid-RUN: eng_start, busy, pix_we low immediately, no ack; after release req=0010 → client 1 granted next cycle.
